// File: rtl/mem_responder.sv
// Memory-side responder: valid/ready request port, lane-masked stores, wait-stated loads
// from an internal word-organised RAM. Optional store protection: MEM_RESPONDER_WPROT_EN.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] WPROT_LIMIT = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] WORD_LIM  = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [1:0]              size_q, size_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic                    req_err;
    logic                    access;
    logic                    acc_wr;
    logic [1:0]              acc_size;
    logic [ADDR_WIDTH+1:0]   acc_addr;
    logic [31:0]             acc_wdata;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [3:0]              lane_en;
    logic [31:0]             lane_data;
    logic [31:0]             rd_word;
    logic [31:0]             rd_shift;
    logic [31:0]             load_data;

    logic [31:0]             mem [DEPTH];

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'd1:    req_err = req_addr[0];
            2'd2:    req_err = |req_addr[1:0];
            2'd3:    req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({2'b00, req_addr[31:2]} >= WORD_LIM) begin
            req_err = 1'b1;
        end
`ifdef MEM_RESPONDER_WPROT_EN
        if (req_write && (req_addr < WPROT_LIMIT)) begin
            req_err = 1'b1;
        end
`endif
    end

    // With zero wait states the access happens on the accept edge, so it must
    // use the live request rather than the captured copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_wr    = req_write;
            acc_size  = req_size;
            acc_addr  = req_addr[ADDR_WIDTH+1:0];
            acc_wdata = req_wdata;
        end else begin
            acc_wr    = wr_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_idx = acc_addr[ADDR_WIDTH+1:2];
    end

    always_comb begin
        lane_en   = 4'b1111;
        lane_data = acc_wdata;
        case (acc_size)
            2'd0: begin
                lane_en   = 4'b0001 << acc_addr[1:0];
                lane_data = {4{acc_wdata[7:0]}};
            end
            2'd1: begin
                lane_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = acc_wdata;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem[acc_idx];
        rd_shift = rd_word >> {acc_addr[1:0], 3'b000};
        case (acc_size)
            2'd0:    load_data = {24'd0, rd_shift[7:0]};
            2'd1:    load_data = {16'd0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        access  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_d    = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr[ADDR_WIDTH+1:0];
                    wdata_d = req_wdata;
                    if (req_err) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (access) begin
            err_d   = 1'b0;
            rdata_d = acc_wr ? '0 : load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is deliberately outside reset; a store in WAIT is dropped because
    // reset forces the FSM back to IDLE before any commit edge.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (access && acc_wr && lane_en[i]) begin
                mem[acc_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (1 and 4 wait states) checked against a byte-level model.
module tb_mem_responder;

    localparam int unsigned AW = 10;
`ifdef MEM_RESPONDER_WPROT_EN
    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam bit          WPROT = 1'b1;
`else
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam bit          WPROT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        req_ready_a, req_ready_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        rsp_err_a, rsp_err_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] mbytes [2][4096];

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1), .WPROT_LIMIT(32'h0000_0400)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
        .rsp_err(rsp_err_a), .busy(busy_a)
    );

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(4), .WPROT_LIMIT(32'h0000_0400)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
        .rsp_err(rsp_err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_err(input bit w, input logic [1:0] sz, input logic [31:0] a);
        bit e;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        if (a >= 32'd4096) e = 1'b1;
        if (WPROT && w && a < 32'h0000_0400) e = 1'b1;
        return e;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    task automatic m_store(input int s, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) mbytes[s][a + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] m_load(input int s, input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < nbytes(sz); i++) v = v | (32'(mbytes[s][a + i]) << (8 * i));
        return v;
    endfunction

    // One request through the chosen instance; lat counts edges from accept (inclusive) to rsp_valid.
    task automatic xact(input int s, input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        req_write = w; req_size = sz; req_addr = a; req_wdata = d;
        if (s == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
        guard = 0;
        while (!(s == 0 ? req_ready_a : req_ready_b) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        lat = 1;
        while (!(s == 0 ? rsp_valid_a : rsp_valid_b) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = (s == 0) ? rsp_rdata_a : rsp_rdata_b;
        er = (s == 0) ? rsp_err_a : rsp_err_b;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready_a); end
        checks++; if ({rsp_valid_a, rsp_err_a, busy_a, rsp_valid_b, busy_b} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {rsp_valid_a, rsp_err_a, busy_a, rsp_valid_b, busy_b}); end
        checks++; if (rsp_rdata_a !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata_a); end
        rst = 1'b0;
        #1;
        checks++; if ({req_ready_a, req_ready_b} !== 2'b11) begin errors++; $display("FAIL idle_ready got %b exp 11", {req_ready_a, req_ready_b}); end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd; logic er; int lat;
        xact(0, 1'b1, 2'd2, BASE + 32'h40, 32'hDEAD_BEEF, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d exp 2", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err got %b exp 0", er); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL store_rdata got %h exp 0", rd); end
        xact(0, 1'b0, 2'd2, BASE + 32'h40, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load got %h exp deadbeef", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat); end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic er; int lat;
        xact(0, 1'b1, 2'd2, BASE + 32'h80, 32'h1122_3344, rd, er, lat);
        xact(0, 1'b1, 2'd0, BASE + 32'h82, 32'h5555_55AA, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL byte_store_err got %b exp 0", er); end
        xact(0, 1'b0, 2'd2, BASE + 32'h80, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h11AA_3344) begin errors++; $display("FAIL lane_word got %h exp 11aa3344", rd); end
        xact(0, 1'b0, 2'd1, BASE + 32'h82, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000_11AA) begin errors++; $display("FAIL lane_half got %h exp 000011aa", rd); end
        xact(0, 1'b0, 2'd0, BASE + 32'h83, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL lane_byte got %h exp 00000011", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        bit          ew [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  es [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] ea [4];
        ea[0] = BASE + 32'h81; ea[1] = BASE + 32'h42; ea[2] = BASE + 32'h80; ea[3] = 32'd4 << AW;
        for (int i = 0; i < 4; i++) begin
            xact(0, ew[i], es[i], ea[i], 32'hFFFF_FFFF, rd, er, lat);
            checks++; if (er !== 1'b1 || lat !== 1) begin
                errors++; $display("FAIL error_case%0d got err=%b lat=%0d exp err=1 lat=1", i, er, lat); end
        end
        xact(0, 1'b0, 2'd2, BASE + 32'h40, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_ram_40 got %h exp deadbeef", rd); end
        xact(0, 1'b0, 2'd2, BASE + 32'h80, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h11AA_3344) begin errors++; $display("FAIL err_ram_80 got %h exp 11aa3344", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int guard;
        xact(0, 1'b1, 2'd2, BASE + 32'hC0, 32'h1234_5678, rd, er, lat);
        @(negedge clk);
        req_write = 1'b0; req_size = 2'd2; req_addr = BASE + 32'hC0; req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        guard = 0;
        while (!rsp_valid_a && guard < 20) begin @(posedge clk); #1; guard++; end
        req_write = 1'b1; req_wdata = 32'h0BAD_0BAD; req_valid_a = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid_a !== 1'b1 || rsp_rdata_a !== 32'h1234_5678 || req_ready_a !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d got v=%b d=%h rdy=%b exp v=1 d=12345678 rdy=0",
                                   c, rsp_valid_a, rsp_rdata_a, req_ready_a); end
        end
        @(negedge clk); req_valid_a = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        checks++; if ({rsp_valid_a, busy_a, req_ready_a} !== 3'b001) begin
            errors++; $display("FAIL release_idle got v/busy/rdy=%b exp 001", {rsp_valid_a, busy_a, req_ready_a}); end
        xact(0, 1'b0, 2'd2, BASE + 32'hC0, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ignored_req got %h exp 12345678", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat;
        xact(1, 1'b1, 2'd2, BASE + 32'h10, 32'd0, rd, er, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wait4_latency got %0d exp 5", lat); end
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd2; req_addr = BASE + 32'h10; req_wdata = 32'hCAFE_F00D; req_valid_b = 1'b1;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL wait_busy got %b exp 1", busy_b); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if ({busy_b, rsp_valid_b, rsp_err_b, req_ready_b} !== 4'b0 || rsp_rdata_b !== 32'd0) begin
            errors++; $display("FAIL async_reset got busy/v/err/rdy=%b d=%h exp 0000 d=0",
                               {busy_b, rsp_valid_b, rsp_err_b, req_ready_b}, rsp_rdata_b); end
        @(negedge clk); rst = 1'b0;
        xact(1, 1'b0, 2'd2, BASE + 32'h10, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL dropped_store got %h exp 0", rd); end
        xact(0, 1'b0, 2'd2, BASE + 32'h40, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_survives_reset got %h exp deadbeef", rd); end
    endtask

    task automatic test_wprot();
        logic [31:0] rd, old; logic er; int lat;
        xact(0, 1'b0, 2'd2, 32'h3FC, 32'd0, old, er, lat);
        xact(0, 1'b1, 2'd2, 32'h3FC, 32'h5A5A_5A5A, rd, er, lat);
        checks++; if (er !== WPROT || lat !== (WPROT ? 1 : 2)) begin
            errors++; $display("FAIL wprot_below got err=%b lat=%0d exp err=%b lat=%0d", er, lat, WPROT, WPROT ? 1 : 2); end
        xact(0, 1'b0, 2'd2, 32'h3FC, 32'd0, rd, er, lat);
        checks++; if (rd !== (WPROT ? old : 32'h5A5A_5A5A)) begin
            errors++; $display("FAIL wprot_data got %h exp %h", rd, WPROT ? old : 32'h5A5A_5A5A); end
        xact(0, 1'b1, 2'd2, 32'h400, 32'hA5A5_0400, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wprot_limit_store got err=%b exp 0", er); end
        xact(0, 1'b0, 2'd2, 32'h400, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hA5A5_0400) begin errors++; $display("FAIL wprot_limit_load got %h exp a5a50400", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp_rd; logic er; int lat, exp_lat, s; bit w, exp_er; logic [1:0] sz;
        for (int si = 0; si < 2; si++) begin
            for (int wi = 0; wi < 16; wi++) begin
                d = $urandom;
                a = BASE + 32'(wi * 4);
                xact(si, 1'b1, 2'd2, a, d, rd, er, lat);
                m_store(si, 2'd2, a, d);
                checks++; if (er !== 1'b0) begin errors++; $display("FAIL rand_init%0d_%0d got err=%b exp 0", si, wi, er); end
            end
        end
        for (int n = 0; n < 60; n++) begin
            s  = int'($urandom_range(1, 0));
            w  = 1'($urandom_range(1, 0));
            sz = 2'($urandom_range(3, 0));
            d  = $urandom;
            if ($urandom_range(9, 0) == 0) a = 32'h1000 + 32'($urandom_range(63, 0));
            else a = BASE + 32'($urandom_range(63, 0));
            exp_er  = m_err(w, sz, a);
            exp_lat = exp_er ? 1 : (s == 0 ? 2 : 5);
            exp_rd  = (exp_er || w) ? 32'd0 : m_load(s, sz, a);
            xact(s, w, sz, a, d, rd, er, lat);
            if (!exp_er && w) m_store(s, sz, a, d);
            checks++; if (er !== exp_er || lat !== exp_lat || (!exp_er && rd !== exp_rd)) begin
                errors++; $display("FAIL rand%0d dut%0d w=%b sz=%0d a=%h got err=%b lat=%0d d=%h exp err=%b lat=%0d d=%h",
                                   n, s, w, sz, a, er, lat, rd, exp_er, exp_lat, exp_rd); end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_write = 1'b0; req_size = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b0;
        test_reset();
        test_word_store_load();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_wprot();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
